// File: rtl/cam_pkg.sv
// Shared types and sizing for the CAM match-result path.
// Line count, address/count widths and the match sequencer state encoding.
package cam_pkg;

   localparam int CAM_LINES  = 128;
   localparam int CAM_ADDR_W = 7;

   typedef logic [CAM_ADDR_W-1:0] cam_addr_t;
   typedef logic [CAM_ADDR_W:0]   cam_cnt_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } match_seq_state_e;

endpackage

// File: rtl/cam_match_sequencer_if.sv
// Search-in / hit-out / completion bundle of the match sequencer.
// The slave modport is the sequencer's view; master is the upstream+consumer side.
interface cam_match_sequencer_if
   import cam_pkg::*;
#(
   parameter int N_LINES = CAM_LINES,
   parameter int ADDR_W  = $clog2(N_LINES)
);

   logic               srch_valid;
   logic               srch_ready;
   logic [N_LINES-1:0] match_vec;
   logic               flush;
   logic               hit_valid;
   logic               hit_ready;
   logic [ADDR_W-1:0]  hit_addr;
   logic               hit_last;
   logic               done_valid;
   logic [ADDR_W:0]    done_count;
   logic               done_miss;
   logic               busy;

   modport slave (
      input  srch_valid, match_vec, flush, hit_ready,
      output srch_ready, hit_valid, hit_addr, hit_last,
             done_valid, done_count, done_miss, busy
   );

   modport master (
      output srch_valid, match_vec, flush, hit_ready,
      input  srch_ready, hit_valid, hit_addr, hit_last,
             done_valid, done_count, done_miss, busy
   );

endinterface

// File: rtl/match_prio_enc.sv
// Highest-index-wins priority encoder, purely combinational (zero latency).
// pos_o is 0 when no bit is set; any_o flags a non-empty vector.
module match_prio_enc
   import cam_pkg::*;
#(
   parameter int N_LINES = CAM_LINES,
   parameter int ADDR_W  = $clog2(N_LINES)
) (
   input  logic [N_LINES-1:0] vec_i,
   output logic [ADDR_W-1:0]  pos_o,
   output logic               any_o
);

   // Ascending scan so the last (highest) set bit overwrites lower ones.
   always_comb begin
      pos_o = '0;
      for (int i = 0; i < N_LINES; i++) begin
         if (vec_i[i]) begin
            pos_o = ADDR_W'(i);
         end
      end
   end

   assign any_o = |vec_i;

endmodule

// File: rtl/cam_match_sequencer.sv
// Streams every set line of a captured match vector, highest first, one per cycle;
// first hit one cycle after capture, holds stable under hit_ready backpressure, then a 1-cycle done pulse.
module cam_match_sequencer
   import cam_pkg::*;
#(
   parameter int N_LINES = CAM_LINES,
   parameter int ADDR_W  = $clog2(N_LINES)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   cam_match_sequencer_if.slave bus
);

   localparam logic [N_LINES-1:0] PEND_ONE = {{(N_LINES-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]    CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

   match_seq_state_e   state_q;
   logic [N_LINES-1:0] pend_q;
   logic [ADDR_W:0]    cnt_q;
   logic [ADDR_W:0]    cnt_d;
   logic               srch_rdy_q;
   logic               hit_vld_q;
   logic               done_vld_q;
   logic [ADDR_W:0]    done_cnt_q;
   logic               done_miss_q;
   logic               busy_q;

   logic [ADDR_W-1:0]  top_pos;
   logic               pend_any;
   logic               pend_single;
   logic               hit_last;

   match_prio_enc #(
      .N_LINES (N_LINES),
      .ADDR_W  (ADDR_W)
   ) u_prio_enc (
      .vec_i (pend_q),
      .pos_o (top_pos),
      .any_o (pend_any)
   );

   assign cnt_d       = cnt_q + CNT_ONE;
   assign pend_single = ((pend_q & (pend_q - PEND_ONE)) == '0);
   assign hit_last    = hit_vld_q & pend_any & pend_single;

   // Flush shares the reset path so an aborted search leaves no trace.
   always_ff @(posedge clk) begin
      if (!rst_n || bus.flush) begin
         state_q     <= IDLE;
         pend_q      <= '0;
         cnt_q       <= '0;
         srch_rdy_q  <= 1'b1;
         hit_vld_q   <= 1'b0;
         done_vld_q  <= 1'b0;
         done_cnt_q  <= '0;
         done_miss_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         done_vld_q  <= 1'b0;
         done_cnt_q  <= '0;
         done_miss_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (bus.srch_valid && srch_rdy_q) begin
                  pend_q     <= bus.match_vec;
                  cnt_q      <= '0;
                  srch_rdy_q <= 1'b0;
                  busy_q     <= 1'b1;
                  if (|bus.match_vec) begin
                     state_q   <= DRAIN;
                     hit_vld_q <= 1'b1;
                  end else begin
                     state_q     <= DONE;
                     done_vld_q  <= 1'b1;
                     done_miss_q <= 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (bus.hit_ready) begin
                  pend_q[top_pos] <= 1'b0;
                  cnt_q           <= cnt_d;
                  if (hit_last) begin
                     state_q     <= DONE;
                     hit_vld_q   <= 1'b0;
                     done_vld_q  <= 1'b1;
                     done_cnt_q  <= cnt_d;
                     done_miss_q <= (cnt_d == '0);
                  end
               end
            end
            DONE: begin
               state_q    <= IDLE;
               srch_rdy_q <= 1'b1;
               busy_q     <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.srch_ready = srch_rdy_q;
   assign bus.hit_valid  = hit_vld_q;
   assign bus.hit_addr   = top_pos;
   assign bus.hit_last   = hit_last;
   assign bus.done_valid = done_vld_q;
   assign bus.done_count = done_cnt_q;
   assign bus.done_miss  = done_miss_q;
   assign bus.busy       = busy_q;

endmodule

// File: doc/cam_match_sequencer.md
Name: cam_match_sequencer

Overview:
- Downstream of the CAM match array.
- Captures one 128-line match vector per search and streams every matching line address out, highest index first, one address per cycle, over a valid/ready handshake.
- Uses a priority encoder on a registered pending-match vector and clears each bit as it is consumed.
- Reports a per-search completion pulse with the total hit count; a dedicated miss indication is given when nothing matched.

Parameters:
- N_LINES, 128, number of CAM lines, i.e. the match vector width.
- ADDR_W, 7, address width; equals clog2(N_LINES).

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- srch_valid  input  1  match vector presented.
- srch_ready  output  1  block can accept a new match vector.
- match_vec  input  N_LINES  match lines, one bit per CAM line.
- flush  input  1  synchronous abort of the current search.
- hit_valid  output  1  hit_addr holds a valid matching line.
- hit_ready  input  1  consumer accepts hit_addr.
- hit_addr  output  ADDR_W  index of the highest pending match.
- hit_last  output  1  current hit is the final one of this search.
- done_valid  output  1  one-cycle completion pulse.
- done_count  output  ADDR_W+1  number of hits emitted for the search (0..N_LINES).
- done_miss  output  1  qualifies done_valid: the search had zero matches.
- busy  output  1  state is not IDLE.

Behaviour:
- One clock (clk); reset is synchronous, active-low (rst_n).
- Reset values:
  - State = IDLE; pending vector = 0; count = 0.
  - srch_ready = 1.
  - hit_valid, hit_last, done_valid, done_miss, busy = 0.
  - hit_addr = 0; done_count = 0.
- States: IDLE, DRAIN, DONE.
- IDLE:
  - srch_ready = 1.
  - On srch_valid & srch_ready, register match_vec into pend_q and clear cnt_q.
  - Next state is DRAIN if match_vec ≠ 0, else DONE with done_miss = 1.
- DRAIN:
  - srch_ready = 0.
  - hit_valid = 1.
  - hit_addr = index of the highest set bit of pend_q, combinational from the registered pend_q.
  - hit_last = 1 when pend_q has exactly one bit set, tested as (pend_q & (pend_q−1)) == 0.
  - On hit_valid & hit_ready: clear pend_q[hit_addr] and increment cnt_q. If hit_last, go to DONE.
  - Without hit_ready: hit_valid, hit_addr and hit_last hold stable. hit_valid never drops before the handshake.
- DONE:
  - Exactly one cycle.
  - done_valid = 1; done_count = cnt_q; done_miss = 1 iff cnt_q == 0.
  - Next state is IDLE; srch_ready = 0 during DONE.
- Latency and throughput:
  - Vector accepted at cycle t → first hit_valid at t+1.
  - k hits with hit_ready held high → hits at t+1 through t+k, done_valid at t+k+1, srch_ready at t+k+2.
  - Zero vector → done_valid at t+1.
- srch_valid outside IDLE: ignored, vector not captured; the upstream stage holds it per the handshake.
- flush:
  - Takes priority over everything except reset, in any state.
  - Next cycle: IDLE, pend_q = 0, cnt_q = 0, all outputs at reset values.
  - No done pulse is produced for the aborted search.
  - A flush coinciding with a hit handshake still aborts; that hit counts as consumed by the consumer only.
- Reset mid-operation: identical to flush.
- cnt_q width is ADDR_W+1, so an all-ones vector reports 128 without wrap.
- Address width: bits of ADDR_W are derived from N_LINES; no truncation for N_LINES = 2^ADDR_W.

Decomposition:
- Shared package cam_pkg:
  - CAM_LINES = 128 and CAM_ADDR_W = 7.
  - cam_addr_t typedef, logic[CAM_ADDR_W-1:0].
  - cam_cnt_t typedef, logic[CAM_ADDR_W:0].
  - State enum match_seq_state_e {IDLE, DRAIN, DONE}.
- Sub-module: match_prio_enc, a parameterised combinational highest-index-wins encoder.
  - Inputs: vector of width N_LINES.
  - Outputs: pos[ADDR_W-1:0] and any.
  - Instantiated once on pend_q.
  - All other logic stays in cam_match_sequencer.

Test Plan:
- Reset: rst_n low 2 cycles with random inputs → srch_ready = 1, every other output 0; held through release.
- Single match: match_vec = 1<<5, hit_ready = 1 → t+1: hit_addr = 5, hit_last = 1; t+2: done_valid = 1, done_count = 1, done_miss = 0; t+3: srch_ready = 1.
- Multi-match ordering: bits {127,64,0}, hit_ready = 1 → hit_addr 127, 64, 0 on consecutive cycles, hit_last only on 0; done_count = 3.
- Backpressure: same vector, hit_ready low 4 cycles per hit → hit_addr/hit_valid stable while stalled; srch_valid pulsed during DRAIN is not captured; done_count = 3.
- Miss and full: match_vec = 0 → done_valid at t+1, done_miss = 1, done_count = 0, hit_valid never set. All-ones vector → 128 hits in descending order 127..0, done_count = 128.
- Flush/reset mid-drain: bits {100,50,10}, flush after the first handshake → next cycle IDLE, hit_valid = 0, no done_valid; repeat using rst_n low instead of flush → same result.
